// File: rtl/disp_pkg.sv
// Shared 7-segment constants and BCD decode helper for the display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, lit = 1.
package disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Codes A-F are not valid BCD and show a dash rather than a hex glyph.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Purely combinational 4-bit BCD to 7-segment decoder, lit-high output.
module bcd_seg_decoder
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_lit
);

    always_comb begin
        seg_lit = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with BCD snapshot and leading-zero blanking.
// Optional whole-display flashing is built in when DISP_BLINK_EN is defined.
module bcd_display_scanner
    import disp_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int BLINK_DIV      = 64
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [4*DIGITS-1:0]       bcd_in,
    input  logic                      bcd_valid,
    input  logic                      blank_lz,
`ifdef DISP_BLINK_EN
    input  logic                      blink,
`endif
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         an,
    output logic [$clog2(DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);

    localparam logic [6:0]        SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                slot_done;
    logic [3:0]          digit_val;
    logic [6:0]          seg_lit;
    logic [6:0]          seg_sel;
    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   blank_mask;
    logic                blank_sel;
    logic                lead_zero;
    logic                blink_gate;

    bcd_seg_decoder u_dec (
        .bcd     (digit_val),
        .seg_lit (seg_lit)
    );

    // Digit i is a leading zero when every shadow digit from the top down to i is zero.
    always_comb begin
        lead_zero  = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_zero     = lead_zero & (shadow_q[4*i +: 4] == 4'd0);
            blank_mask[i] = lead_zero;
        end
    end

    always_comb begin
        slot_done = (presc_q == PRE_W'(SCAN_DIV - 1));
        presc_d   = slot_done ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (slot_done) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        shadow_d = bcd_valid ? bcd_in : shadow_q;

        digit_val = 4'd0;
        blank_sel = 1'b0;
        an_sel    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                digit_val = shadow_q[4*i +: 4];
                blank_sel = blank_mask[i];
                an_sel[i] = 1'b1;
            end
        end

        // Anodes stay off in the first cycle of each slot so the new segments settle first.
        if (presc_d == '0 || blink_gate) begin
            an_sel = '0;
        end

        seg_sel = (blank_lz && blank_sel) ? SEG_OFF : seg_lit;
        seg_d   = SEG_ACTIVE_LOW ? ~seg_sel : seg_sel;
        an_d    = AN_ACTIVE_LOW ? ~an_sel : an_sel;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            shadow_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_IDLE;
            an_q     <= AN_IDLE;
        end else begin
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_off_q, blink_off_d;

    // The phase keeps advancing while blink is low so re-enabling resumes the same cadence.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (slot_done) begin
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        blink_gate = blink && blink_off_d;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end
`else
    // BLINK_DIV has no effect in this build; fold it into a dummy so it is not left dangling.
    logic unused_blink_div;
    assign unused_blink_div = ^BLINK_DIV;
    assign blink_gate       = 1'b0;
`endif

    assign seg       = seg_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule
